bkm_steps_driver: RTL and testbench

Stimulus-side counterpart of the bkm_steps monitor. It accepts binary two's-complement operands through a valid/ready handshake and recodes X and Y into the canonical-signed-digit (CSD) bus format consumed by bkm_steps, processing DPC digits per cycle. It presents the result as a stable, held transaction with u/v passed through. It sits between the testbench sequencer and the bkm_steps DUT inputs, and is synthesizable so it can be reused as an RTL front end.

---
 rtl/bkm_csd_pkg.sv | 23 ++
 rtl/bkm_steps_driver_if.sv | 30 +++
 rtl/bkm_csd_recoder_slice.sv | 30 +++
 rtl/bkm_steps_driver.sv | 157 +++++++++++++++
 tb/tb_bkm_steps_driver.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bkm_csd_pkg.sv
// Shared CSD definitions for the bkm_steps driver and monitor: digit codes,
// driver FSM states and a digit-to-integer helper.
package bkm_csd_pkg;

    localparam logic [1:0] CSD_ZERO = 2'b00;
    localparam logic [1:0] CSD_POS  = 2'b10;
    localparam logic [1:0] CSD_NEG  = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } drv_state_t;

    function automatic int csd_digit_value(input logic [1:0] digit);
        case (digit)
            CSD_POS: return 1;
            CSD_NEG: return -1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/bkm_steps_driver_if.sv
// Operand and CSD-result channels between the stimulus sequencer (master)
// and the bkm_steps_driver front end (slave).
interface bkm_steps_driver_if #(
    parameter int WD = 72,
    parameter int WC = 21
);
    logic            in_valid;
    logic            in_ready;
    logic [WD-1:0]   X_in_bin;
    logic [WD-1:0]   Y_in_bin;
    logic [WC-1:0]   u_in_bin;
    logic [WC-1:0]   v_in_bin;
    logic            out_valid;
    logic            out_ready;
    logic [2*WD-1:0] X_out_csd;
    logic [2*WD-1:0] Y_out_csd;
    logic [WC-1:0]   u_out_bin;
    logic [WC-1:0]   v_out_bin;

    modport master (
        output in_valid, X_in_bin, Y_in_bin, u_in_bin, v_in_bin, out_ready,
        input  in_ready, out_valid, X_out_csd, Y_out_csd, u_out_bin, v_out_bin
    );

    modport slave (
        input  in_valid, X_in_bin, Y_in_bin, u_in_bin, v_in_bin, out_ready,
        output in_ready, out_valid, X_out_csd, Y_out_csd, u_out_bin, v_out_bin
    );

endinterface

// File: rtl/bkm_csd_recoder_slice.sv
// Combinational Reitwiesner recoder for DPC digits; bits_in[DPC] is the
// look-ahead bit from the next slice (or the sign for the top slice).
module bkm_csd_recoder_slice #(
    parameter int DPC = 8
) (
    input  logic [DPC:0]     bits_in,
    input  logic             carry_in,
    output logic [2*DPC-1:0] csd_out,
    output logic             carry_out
);

    logic [DPC:0] carry;

    assign carry[0] = carry_in;

    // The carry is the majority of x_i, x_i+1 and c_i; a nonzero digit appears
    // when x_i + c_i is odd, its sign given by whether a carry is generated.
    for (genvar i = 0; i < DPC; i++) begin : g_digit
        logic odd;
        assign odd          = bits_in[i] ^ carry[i];
        assign carry[i+1]   = (bits_in[i] & bits_in[i+1]) |
                              (bits_in[i] & carry[i]) |
                              (bits_in[i+1] & carry[i]);
        assign csd_out[2*i+1] = odd & ~carry[i+1];
        assign csd_out[2*i]   = odd & carry[i+1];
    end

    assign carry_out = carry[DPC];

endmodule

// File: rtl/bkm_steps_driver.sv
// Binary-to-CSD stimulus front end for bkm_steps: accepts X/Y/u/v operands and
// recodes X and Y DPC digits per cycle into a held CSD transaction.
module bkm_steps_driver
    import bkm_csd_pkg::*;
#(
    parameter int WD  = 72,
    parameter int WC  = 21,
    parameter int DPC = 8
) (
    input  logic clk,
    input  logic arst,
    input  logic srst,
    input  logic enable,
    bkm_steps_driver_if.slave bus
);

    localparam int NSLICE = WD / DPC;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WD % DPC != 0) begin : g_bad_dpc
        $error("bkm_steps_driver: WD must be a multiple of DPC");
    end

    drv_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [WD-1:0]    x_reg, y_reg;
    logic             carry_x, carry_y;
    logic [2*WD-1:0]  x_csd, y_csd;
    logic [WC-1:0]    u_reg, v_reg;
    logic             accept, step, last_slice;
    logic [WD:0]      x_ext, y_ext;
    logic [DPC:0]     x_slice, y_slice;
    logic [2*DPC-1:0] x_slice_csd, y_slice_csd;
    logic             x_carry_out, y_carry_out;

    assign last_slice = (cnt == CNT_W'(NSLICE - 1));

    // Replicating the sign bit gives the top slice its sign-extended look-ahead.
    assign x_ext = {x_reg[WD-1], x_reg};
    assign y_ext = {y_reg[WD-1], y_reg};

    always_comb begin
        x_slice = '0;
        y_slice = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (cnt == CNT_W'(s)) begin
                x_slice = x_ext[s*DPC +: DPC+1];
                y_slice = y_ext[s*DPC +: DPC+1];
            end
        end
    end

    bkm_csd_recoder_slice #(.DPC(DPC)) u_rec_x (
        .bits_in   (x_slice),
        .carry_in  (carry_x),
        .csd_out   (x_slice_csd),
        .carry_out (x_carry_out)
    );

    bkm_csd_recoder_slice #(.DPC(DPC)) u_rec_y (
        .bits_in   (y_slice),
        .carry_in  (carry_y),
        .csd_out   (y_slice_csd),
        .carry_out (y_carry_out)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= IDLE;
        end else if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every transition is qualified by enable so a low enable freezes the FSM.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (enable) begin
                    step = 1'b1;
                    if (last_slice) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (enable && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // CSD registers are overwritten slice by slice rather than cleared on
    // acceptance, so the previous result stays visible until CONV starts.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt     <= '0;
            carry_x <= 1'b0;
            carry_y <= 1'b0;
            x_reg   <= '0;
            y_reg   <= '0;
            u_reg   <= '0;
            v_reg   <= '0;
            x_csd   <= {WD{CSD_ZERO}};
            y_csd   <= {WD{CSD_ZERO}};
        end else if (srst) begin
            cnt     <= '0;
            carry_x <= 1'b0;
            carry_y <= 1'b0;
            x_reg   <= '0;
            y_reg   <= '0;
            u_reg   <= '0;
            v_reg   <= '0;
            x_csd   <= {WD{CSD_ZERO}};
            y_csd   <= {WD{CSD_ZERO}};
        end else if (accept) begin
            cnt     <= '0;
            carry_x <= 1'b0;
            carry_y <= 1'b0;
            x_reg   <= bus.X_in_bin;
            y_reg   <= bus.Y_in_bin;
            u_reg   <= bus.u_in_bin;
            v_reg   <= bus.v_in_bin;
        end else if (step) begin
            for (int s = 0; s < NSLICE; s++) begin
                if (cnt == CNT_W'(s)) begin
                    x_csd[s*2*DPC +: 2*DPC] <= x_slice_csd;
                    y_csd[s*2*DPC +: 2*DPC] <= y_slice_csd;
                end
            end
            carry_x <= x_carry_out;
            carry_y <= y_carry_out;
            cnt     <= last_slice ? '0 : cnt + 1'b1;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && enable;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.X_out_csd = x_csd;
    assign bus.Y_out_csd = y_csd;
    assign bus.u_out_bin = u_reg;
    assign bus.v_out_bin = v_reg;

endmodule

// File: tb/tb_bkm_steps_driver.sv
// Randomized and directed bench for bkm_steps_driver; expected CSD comes from
// an integer non-adjacent-form model, transaction order from a queue scoreboard.
module tb_bkm_steps_driver;

    localparam int WD  = 72;
    localparam int WC  = 21;
    localparam int DPC = 8;
    localparam int LAT = WD / DPC + 1;

    logic clk;
    logic arst;
    logic srst;
    logic enable;

    int n_compared   = 0;
    int n_mismatched = 0;

    bkm_steps_driver_if #(.WD(WD), .WC(WC)) bus ();
    bkm_steps_driver_if #(.WD(8),  .WC(WC)) bus8 ();

    bkm_steps_driver #(.WD(WD), .WC(WC), .DPC(DPC)) dut (
        .clk    (clk),
        .arst   (arst),
        .srst   (srst),
        .enable (enable),
        .bus    (bus.slave)
    );

    bkm_steps_driver #(.WD(8), .WC(WC), .DPC(4)) dut8 (
        .clk    (clk),
        .arst   (arst),
        .srst   (srst),
        .enable (enable),
        .bus    (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Non-adjacent form of the signed value: peel off the lowest digit, choosing
    // -1 when the value is 3 mod 4 so the next digit is forced to zero.
    function automatic logic [2*WD-1:0] naf72(input logic [WD-1:0] x);
        logic signed [WD+7:0] n = {{8{x[WD-1]}}, x};
        logic [2*WD-1:0] r = '0;
        for (int i = 0; i < WD; i++) begin
            if (n[0]) begin
                if (n[1]) begin
                    r[2*i +: 2] = 2'b01;
                    n = n + 1;
                end else begin
                    r[2*i +: 2] = 2'b10;
                    n = n - 1;
                end
            end
            n = n >>> 1;
        end
        return r;
    endfunction

    function automatic logic [WD-1:0] rand_operand();
        logic [95:0] r = {$urandom(), $urandom(), $urandom()};
        case ($urandom_range(9, 0))
            0:       return {1'b0, {(WD-1){1'b1}}};
            1:       return {1'b1, {(WD-1){1'b0}}};
            2:       return '0;
            3:       return '1;
            4:       return {(WD/2){2'b01}};
            default: return r[WD-1:0];
        endcase
    endfunction

    task automatic applyStimulus(input logic [WD-1:0] x, input logic [WD-1:0] y,
                                 input logic [WC-1:0] u, input logic [WC-1:0] v,
                                 output int lat);
        int guard = 0;
        @(negedge clk);
        bus.X_in_bin = x;
        bus.Y_in_bin = y;
        bus.u_in_bin = u;
        bus.v_in_bin = v;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic popResult();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_compared++;
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_compared++;
        if (bus.X_out_csd !== '0 || bus.Y_out_csd !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_csd: got X=%h Y=%h expected 0", bus.X_out_csd, bus.Y_out_csd);
        end
        n_compared++;
        if (bus.u_out_bin !== '0 || bus.v_out_bin !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_uv: got u=%h v=%h expected 0", bus.u_out_bin, bus.v_out_bin);
        end
        n_compared++;
        if (bus.in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_in_ready_en: got %b expected 1", bus.in_ready);
        end
        enable = 1'b0;
        #1;
        n_compared++;
        if (bus.in_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_in_ready_dis: got %b expected 0", bus.in_ready);
        end
        enable = 1'b1;
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_small_vectors();
        logic [7:0]  vx [2] = '{8'h07, 8'h80};
        logic [7:0]  vy [2] = '{8'hF8, 8'hFF};
        logic [15:0] ex [2] = '{16'h0081, 16'h4000};
        logic [15:0] ey [2] = '{16'h0040, 16'h0001};
        int lat;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus8.X_in_bin = vx[k];
            bus8.Y_in_bin = vy[k];
            bus8.u_in_bin = WC'(k + 5);
            bus8.v_in_bin = WC'(k + 9);
            bus8.in_valid = 1'b1;
            @(negedge clk);
            bus8.in_valid = 1'b0;
            lat = 1;
            while (!bus8.out_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            n_compared++;
            if (lat != 3) begin
                n_mismatched++;
                $display("[TB] FAIL small_latency[%0d]: got %0d expected 3", k, lat);
            end
            n_compared++;
            if (bus8.X_out_csd !== ex[k]) begin
                n_mismatched++;
                $display("[TB] FAIL small_x[%0d]: got %h expected %h", k, bus8.X_out_csd, ex[k]);
            end
            n_compared++;
            if (bus8.Y_out_csd !== ey[k]) begin
                n_mismatched++;
                $display("[TB] FAIL small_y[%0d]: got %h expected %h", k, bus8.Y_out_csd, ey[k]);
            end
            bus8.out_ready = 1'b1;
            @(negedge clk);
            bus8.out_ready = 1'b0;
        end
    endtask

    task automatic test_random(input int n_txn);
        logic [WD-1:0] qx[$];
        logic [WD-1:0] qy[$];
        logic [WC-1:0] qu[$];
        logic [WC-1:0] qv[$];
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        logic acc = 1'b0;
        logic pop;
        while (got < n_txn && cyc < 40 * n_txn) begin
            @(negedge clk);
            cyc++;
            if (acc) bus.in_valid = 1'b0;
            if (!bus.in_valid && sent < n_txn && $urandom_range(3, 0) != 0) begin
                bus.X_in_bin = rand_operand();
                bus.Y_in_bin = rand_operand();
                bus.u_in_bin = WC'($urandom());
                bus.v_in_bin = WC'($urandom());
                bus.in_valid = 1'b1;
            end
            bus.out_ready = 1'($urandom_range(1, 0));
            #1;
            acc = bus.in_valid && bus.in_ready;
            pop = bus.out_valid && bus.out_ready;
            if (pop) begin
                n_compared++;
                if (qx.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_dup: got extra transaction %0d expected none", got);
                end else begin
                    if (bus.X_out_csd !== naf72(qx[0])) begin
                        n_mismatched++;
                        $display("[TB] FAIL rand_x[%0d]: got %h expected %h", got, bus.X_out_csd, naf72(qx[0]));
                    end
                    n_compared++;
                    if (bus.Y_out_csd !== naf72(qy[0])) begin
                        n_mismatched++;
                        $display("[TB] FAIL rand_y[%0d]: got %h expected %h", got, bus.Y_out_csd, naf72(qy[0]));
                    end
                    n_compared++;
                    if (bus.u_out_bin !== qu[0] || bus.v_out_bin !== qv[0]) begin
                        n_mismatched++;
                        $display("[TB] FAIL rand_uv[%0d]: got %h/%h expected %h/%h", got,
                                 bus.u_out_bin, bus.v_out_bin, qu[0], qv[0]);
                    end
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                    void'(qu.pop_front());
                    void'(qv.pop_front());
                end
                got++;
            end
            if (acc) begin
                qx.push_back(bus.X_in_bin);
                qy.push_back(bus.Y_in_bin);
                qu.push_back(bus.u_in_bin);
                qv.push_back(bus.v_in_bin);
                sent++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n_compared++;
        if (got != n_txn || sent != got || qx.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL rand_count: got sent=%0d popped=%0d pending=%0d expected %0d each, 0 pending",
                     sent, got, qx.size(), n_txn);
        end
    endtask

    task automatic test_hold_backpressure();
        logic [WD-1:0] x = rand_operand();
        logic [WD-1:0] y = rand_operand();
        logic [WC-1:0] u = WC'($urandom());
        logic [WC-1:0] v = WC'($urandom());
        int accepts = 0;
        int waited = 0;
        int unstable = 0;
        int ready_seen = 0;
        @(negedge clk);
        bus.X_in_bin  = x;
        bus.Y_in_bin  = y;
        bus.u_in_bin  = u;
        bus.v_in_bin  = v;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        while (!bus.out_valid && waited < 50) begin
            if (bus.in_ready) accepts++;
            @(negedge clk);
            #1;
            waited++;
        end
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) begin
                ready_seen++;
                accepts++;
            end
            if (!bus.out_valid || bus.X_out_csd !== naf72(x) || bus.Y_out_csd !== naf72(y) ||
                bus.u_out_bin !== u || bus.v_out_bin !== v) unstable++;
            @(negedge clk);
            #1;
        end
        n_compared++;
        if (accepts != 1) begin
            n_mismatched++;
            $display("[TB] FAIL hold_accepts: got %0d expected 1", accepts);
        end
        n_compared++;
        if (ready_seen != 0) begin
            n_mismatched++;
            $display("[TB] FAIL hold_in_ready: got %0d ready cycles expected 0", ready_seen);
        end
        n_compared++;
        if (unstable != 0) begin
            n_mismatched++;
            $display("[TB] FAIL hold_stable: got %0d deviating cycles expected 0", unstable);
        end
        bus.in_valid = 1'b0;
        popResult();
        n_compared++;
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL hold_pop: got out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_enable_freeze();
        logic [WD-1:0] x = rand_operand();
        logic [WD-1:0] y = rand_operand();
        int lat;
        int bad = 0;
        @(negedge clk);
        bus.X_in_bin  = x;
        bus.Y_in_bin  = y;
        bus.u_in_bin  = 21'h1ABCD;
        bus.v_in_bin  = 21'h05432;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        n_compared++;
        if (bus.in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL freeze_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) bad++;
        end
        enable = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatched++;
            $display("[TB] FAIL freeze_idle: got %0d active cycles expected 0", bad);
        end
        n_compared++;
        if (lat != LAT + 5) begin
            n_mismatched++;
            $display("[TB] FAIL freeze_latency: got %0d expected %0d", lat, LAT + 5);
        end
        n_compared++;
        if (bus.X_out_csd !== naf72(x) || bus.Y_out_csd !== naf72(y)) begin
            n_mismatched++;
            $display("[TB] FAIL freeze_result: got X=%h Y=%h expected X=%h Y=%h",
                     bus.X_out_csd, bus.Y_out_csd, naf72(x), naf72(y));
        end
        @(negedge clk);
        n_compared++;
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL one_cycle_valid: got %b expected 0", bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_enable_hold();
        logic [WD-1:0] x = rand_operand();
        int lat;
        int bad = 0;
        bus.out_ready = 1'b0;
        applyStimulus(x, ~x, 21'h00777, 21'h1F000, lat);
        enable = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.X_out_csd !== naf72(x)) bad++;
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatched++;
            $display("[TB] FAIL enable_hold: got %0d bad cycles expected 0", bad);
        end
        enable = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_compared++;
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL enable_hold_pop: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_arst_mid();
        logic [WD-1:0] x = rand_operand();
        logic [WD-1:0] y = rand_operand();
        int lat;
        @(negedge clk);
        bus.X_in_bin  = {WD/8{8'hA5}};
        bus.Y_in_bin  = {WD/8{8'h3C}};
        bus.u_in_bin  = 21'h12345;
        bus.v_in_bin  = 21'h0F0F0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        arst = 1'b0;
        #1;
        n_compared++;
        if (bus.X_out_csd !== '0 || bus.Y_out_csd !== '0 || bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL arst_clear: got X=%h Y=%h valid=%b expected all 0",
                     bus.X_out_csd, bus.Y_out_csd, bus.out_valid);
        end
        n_compared++;
        if (bus.u_out_bin !== '0 || bus.v_out_bin !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL arst_uv: got %h/%h expected 0", bus.u_out_bin, bus.v_out_bin);
        end
        @(negedge clk);
        arst = 1'b1;
        applyStimulus(x, y, 21'h0ABCD, 21'h1DCBA, lat);
        n_compared++;
        if (lat != LAT) begin
            n_mismatched++;
            $display("[TB] FAIL arst_latency: got %0d expected %0d", lat, LAT);
        end
        n_compared++;
        if (bus.X_out_csd !== naf72(x) || bus.Y_out_csd !== naf72(y) ||
            bus.u_out_bin !== 21'h0ABCD || bus.v_out_bin !== 21'h1DCBA) begin
            n_mismatched++;
            $display("[TB] FAIL arst_next: got X=%h Y=%h expected X=%h Y=%h",
                     bus.X_out_csd, bus.Y_out_csd, naf72(x), naf72(y));
        end
        popResult();
    endtask

    task automatic test_srst_hold();
        logic [WD-1:0] x = rand_operand();
        int lat;
        bus.out_ready = 1'b0;
        applyStimulus(x, x, 21'h1FFFF, 21'h00001, lat);
        n_compared++;
        if (bus.out_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL srst_reach_hold: got %b expected 1", bus.out_valid);
        end
        srst   = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        n_compared++;
        if (bus.out_valid !== 1'b0 || bus.X_out_csd !== '0 || bus.Y_out_csd !== '0 ||
            bus.u_out_bin !== '0 || bus.v_out_bin !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL srst_clear: got valid=%b X=%h u=%h expected all 0",
                     bus.out_valid, bus.X_out_csd, bus.u_out_bin);
        end
        srst   = 1'b0;
        enable = 1'b1;
        #1;
        n_compared++;
        if (bus.in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL srst_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    initial begin
        arst   = 1'b0;
        srst   = 1'b0;
        enable = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.X_in_bin  = '0;
        bus.Y_in_bin  = '0;
        bus.u_in_bin  = '0;
        bus.v_in_bin  = '0;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        bus8.X_in_bin  = '0;
        bus8.Y_in_bin  = '0;
        bus8.u_in_bin  = '0;
        bus8.v_in_bin  = '0;

        test_reset();
        test_small_vectors();
        test_random(1500);
        test_hold_backpressure();
        test_enable_freeze();
        test_enable_hold();
        test_arst_mid();
        test_srst_hold();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
